audio_arbiter: RTL and testbench
================================

AUDIO_ARBITER -- requirements
Module: audio_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 100000: clk cycles per duration tick (1 ms at 100 MHz); SHALL be at least 2.
REQ-002 Parameter GAP_TICKS, default 10: silent ticks inserted after every sound effect.
REQ-003 Port clk, input, 1: single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port music_en, input, 1: background music enabled.
REQ-006 Port music_tone, input, 32: current music note frequency in Hz from the music table; 0 means rest.
REQ-007 Port req, input, 2: level sound-effect requests; bit0 = click, bit1 = alert.
REQ-008 Ports req_tone0 and req_tone1, input, 32 each: effect frequency in Hz.
REQ-009 Ports req_len0 and req_len1, input, 8 each: effect duration in ticks.
REQ-010 Port grant, output, 2: one-cycle pulse; the bit of the accepted requester.
REQ-011 Port sfx_done, output, 1: one-cycle pulse when an effect completes its full length.
REQ-012 Port busy, output, 1: high in SFX or GAP.
REQ-013 Port music_hold, output, 1: freezes the music beat player while high.
REQ-014 Port tone, output, 32: registered frequency driven to the tone PWM generator; 0 = silence.

Function
REQ-015 The block SHALL implement the states IDLE, MUSIC, SFX and GAP.
REQ-016 IDLE SHALL go to MUSIC when music_en=1 and no request is accepted; MUSIC SHALL go to IDLE when music_en=0.
REQ-017 Request acceptance:
- A request SHALL be accepted only when its req bit is 1 and its req_len is nonzero.
- Requests with req_len=0 SHALL be ignored: no grant, no state change.
REQ-018 Arbitration: in IDLE, MUSIC or GAP, an accepted alert SHALL win over a simultaneous click.
REQ-019 Entering SFX on acceptance:
- pulse the winner's grant bit;
- latch its tone and length;
- restart the tick prescaler;
- go to SFX on the next cycle.
REQ-020 Preemption in SFX:
- An accepted alert SHALL preempt a running click: grant[1] pulses, tone and length are re-latched, the counters restart, and no sfx_done is issued for the click.
- A click SHALL never preempt anything.
- An alert SHALL never preempt an alert.
REQ-021 SFX timing: tone SHALL hold the latched frequency for exactly len*TICK_DIV cycles. On the last cycle, sfx_done SHALL pulse and the state SHALL go to GAP.
REQ-022 GAP timing: tone SHALL be 0 for exactly GAP_TICKS*TICK_DIV cycles. The state SHALL then go to MUSIC if music_en=1, else to IDLE.
REQ-023 An accepted request during GAP SHALL abort the gap and enter SFX as in REQ-019.
REQ-024 Tone output per state:
- IDLE and GAP: tone=0.
- MUSIC: tone=music_tone, registered with 1-cycle latency.
- SFX: tone=latched tone.
REQ-025 busy SHALL be combinational from the current state.
REQ-026 Requests still held high after a grant SHALL be re-accepted once the block returns to IDLE, MUSIC or GAP.

Reset
REQ-027 While reset=1, on each clk edge the block SHALL set:
- state=IDLE;
- tone=0, grant=0, sfx_done=0, busy=0, music_hold=0;
- all counters and latched values to 0.
REQ-028 A reset during SFX or GAP SHALL abort immediately with no sfx_done pulse. The first acceptance SHALL be possible on the first cycle after reset deasserts.

Configuration
REQ-029 Macro AUDIO_ARB_DUCK_EN: when defined, music_hold SHALL be 1 in SFX and GAP, so music pauses and resumes at the same beat.
REQ-030 When AUDIO_ARB_DUCK_EN is undefined, music_hold SHALL be constant 0, and music keeps advancing underneath effects.

Verification
All scenarios use TICK_DIV=4 and GAP_TICKS=2.
REQ-031 Click only: music_en=1, music_tone=262, req=01, req_len0=3, req_tone0=1000 for 1 cycle.
- grant=01 pulse;
- tone=1000 for 12 cycles, then sfx_done pulse;
- tone=0 for 8 cycles, then tone=262.
REQ-032 Simultaneous requests: req=11 in MUSIC -> grant=10 only, tone=req_tone1. The click is served after the gap if still held.
REQ-033 Preemption: alert asserted 5 cycles into a 3-tick click -> grant=10, no sfx_done for the click, alert plays its full req_len1*4 cycles.
REQ-034 Zero length: req=01, req_len0=0 -> no grant, state and tone unchanged, busy=0.
REQ-035 Reset mid-SFX: reset=1 for 1 cycle during SFX -> next cycle tone=0, busy=0, no sfx_done.
REQ-036 Ducking: with AUDIO_ARB_DUCK_EN defined, music_hold=1 across SFX+GAP (20 cycles in REQ-031). With it undefined, music_hold stays 0.

Source files
------------

// File: rtl/audio_arbiter.sv
// Audio source arbiter: background music vs. click/alert sound effects with a silent gap.
// Optional macro AUDIO_ARB_DUCK_EN pauses the music beat player during effects and gaps.
module audio_arbiter #(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        music_en,
  input  logic [31:0] music_tone,
  input  logic [1:0]  req,
  input  logic [31:0] req_tone0,
  input  logic [31:0] req_tone1,
  input  logic [7:0]  req_len0,
  input  logic [7:0]  req_len1,
  output logic [1:0]  grant,
  output logic        sfx_done,
  output logic        busy,
  output logic        music_hold,
  output logic [31:0] tone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUSIC = 2'd1;
  localparam logic [1:0] S_SFX   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int          PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] GAP_LEN = 16'(GAP_TICKS);

  logic [1:0]    state;
  logic [PW-1:0] pre;
  logic [15:0]   ticks;
  logic [31:0]   sfx_tone;
  logic [7:0]    sfx_len;
  logic          sfx_alert;

  logic        acc0, acc1, start, tick_end, phase_end;
  logic [15:0] limit;
  logic [1:0]  rest_state;
  logic [31:0] rest_tone, new_tone;
  logic [7:0]  new_len;

  // Zero-length requests are invisible to the arbiter.
  assign acc0 = req[0] && (req_len0 != 8'd0);
  assign acc1 = req[1] && (req_len1 != 8'd0);

  // Only an alert may interrupt a running click; nothing interrupts an alert.
  assign start = (state == S_SFX) ? (acc1 && !sfx_alert) : (acc0 || acc1);

  assign new_tone = acc1 ? req_tone1 : req_tone0;
  assign new_len  = acc1 ? req_len1  : req_len0;

  assign tick_end   = (pre == PRE_MAX);
  assign limit      = (state == S_SFX) ? {8'd0, sfx_len} : GAP_LEN;
  assign phase_end  = tick_end && (ticks == limit - 16'd1);

  assign rest_state = music_en ? S_MUSIC : S_IDLE;
  assign rest_tone  = music_en ? music_tone : 32'd0;

  assign busy = (state == S_SFX) || (state == S_GAP);

`ifdef AUDIO_ARB_DUCK_EN
  assign music_hold = busy;
`else
  assign music_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tone      <= '0;
      grant     <= '0;
      sfx_done  <= 1'b0;
      pre       <= '0;
      ticks     <= '0;
      sfx_tone  <= '0;
      sfx_len   <= '0;
      sfx_alert <= 1'b0;
    end else begin
      grant    <= '0;
      sfx_done <= 1'b0;
      if (start) begin
        state     <= S_SFX;
        grant     <= acc1 ? 2'b10 : 2'b01;
        sfx_tone  <= new_tone;
        sfx_len   <= new_len;
        sfx_alert <= acc1;
        tone      <= new_tone;
        pre       <= '0;
        ticks     <= '0;
      end else begin
        case (state)
          S_IDLE, S_MUSIC: begin
            state <= rest_state;
            tone  <= rest_tone;
          end
          S_SFX: begin
            tone  <= sfx_tone;
            pre   <= tick_end ? '0 : pre + PW'(1);
            ticks <= tick_end ? ticks + 16'd1 : ticks;
            if (phase_end) begin
              sfx_done <= 1'b1;
              pre      <= '0;
              ticks    <= '0;
              if (GAP_LEN == 16'd0) begin
                state <= rest_state;
                tone  <= rest_tone;
              end else begin
                state <= S_GAP;
                tone  <= '0;
              end
            end
          end
          default: begin
            tone  <= '0;
            pre   <= tick_end ? '0 : pre + PW'(1);
            ticks <= tick_end ? ticks + 16'd1 : ticks;
            if (phase_end) begin
              state <= rest_state;
              tone  <= rest_tone;
              pre   <= '0;
              ticks <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_arbiter.sv
// Scoreboard bench for audio_arbiter: stimulus queues expected output events with their cycle,
// a negedge monitor pops and compares every grant/sfx_done pulse and tone/busy/music_hold change.
module tb_audio_arbiter;
  logic        clk = 1'b0, reset = 1'b1, music_en = 1'b0;
  logic [31:0] music_tone = '0, req_tone0 = '0, req_tone1 = '0;
  logic [1:0]  req = '0;
  logic [7:0]  req_len0 = '0, req_len1 = '0;
  logic [1:0]  grant;
  logic        sfx_done, busy, music_hold;
  logic [31:0] tone;

  audio_arbiter #(.TICK_DIV(4), .GAP_TICKS(2)) dut (
    .clk(clk), .reset(reset), .music_en(music_en), .music_tone(music_tone),
    .req(req), .req_tone0(req_tone0), .req_tone1(req_tone1),
    .req_len0(req_len0), .req_len1(req_len1),
    .grant(grant), .sfx_done(sfx_done), .busy(busy), .music_hold(music_hold), .tone(tone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  bit mon_en = 1'b0;

  localparam int K_GNT = 0, K_DONE = 1, K_TONE = 2, K_BUSY = 3, K_HOLD = 4;
  typedef struct { int c; logic [31:0] v; } ev_t;
  ev_t q_gnt[$], q_done[$], q_tone[$], q_busy[$], q_hold[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic void ex(int k, int c, logic [31:0] v);
    ev_t e;
    e.c = c; e.v = v;
    case (k)
      K_GNT:   q_gnt.push_back(e);
      K_DONE:  q_done.push_back(e);
      K_TONE:  q_tone.push_back(e);
      K_BUSY:  q_busy.push_back(e);
      default: q_hold.push_back(e);
    endcase
  endfunction

  function automatic void ex_busy(int c, logic v);
    ex(K_BUSY, c, {31'd0, v});
`ifdef AUDIO_ARB_DUCK_EN
    ex(K_HOLD, c, {31'd0, v});
`endif
  endfunction

  task automatic pop_chk(int k, string name, logic [31:0] v);
    ev_t e;
    bit have;
    have = 1'b1;
    e.c = 0; e.v = '0;
    case (k)
      K_GNT:   if (q_gnt.size()  != 0) e = q_gnt.pop_front();  else have = 1'b0;
      K_DONE:  if (q_done.size() != 0) e = q_done.pop_front(); else have = 1'b0;
      K_TONE:  if (q_tone.size() != 0) e = q_tone.pop_front(); else have = 1'b0;
      K_BUSY:  if (q_busy.size() != 0) e = q_busy.pop_front(); else have = 1'b0;
      default: if (q_hold.size() != 0) e = q_hold.pop_front(); else have = 1'b0;
    endcase
    n_checks++;
    if (!have)
      $display("FAIL %s: unexpected event value %0d at cycle %0d", name, v, cyc);
    else if (e.c == cyc && e.v == v)
      n_pass++;
    else
      $display("FAIL %s: got %0d at cycle %0d, expected %0d at cycle %0d", name, v, cyc, e.v, e.c);
  endtask

  logic [31:0] prev_tone = '0;
  logic        prev_busy = 1'b0, prev_hold = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant != 2'b00)       pop_chk(K_GNT,  "grant",      {30'd0, grant});
      if (sfx_done)             pop_chk(K_DONE, "sfx_done",   32'd1);
      if (tone != prev_tone)    pop_chk(K_TONE, "tone",       tone);
      if (busy != prev_busy)    pop_chk(K_BUSY, "busy",       {31'd0, busy});
      if (music_hold != prev_hold) pop_chk(K_HOLD, "music_hold", {31'd0, music_hold});
      prev_tone = tone;
      prev_busy = busy;
      prev_hold = music_hold;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    @(posedge clk);
    @(negedge clk);
    chk("reset_grant", {30'd0, grant}, 32'd0);
    chk("reset_sfx_done", {31'd0, sfx_done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_music_hold", {31'd0, music_hold}, 32'd0);
    chk("reset_tone", tone, 32'd0);
    mon_en = 1'b1;
    step(1);
    reset = 1'b0;

    // Click only: 12 cycles of tone, 8 silent, back to music.
    c = cyc; music_en = 1'b1; music_tone = 262;
    ex(K_TONE, c + 1, 262);
    step(2);
    c = cyc; req = 2'b01; req_len0 = 3; req_tone0 = 1000;
    ex(K_GNT, c + 1, 1); ex(K_TONE, c + 1, 1000); ex_busy(c + 1, 1'b1);
    ex(K_DONE, c + 13, 1); ex(K_TONE, c + 13, 0);
    ex(K_TONE, c + 21, 262); ex_busy(c + 21, 1'b0);
    step(1); req = 2'b00;
    step(24);

    // Music tone follows the input with one cycle of latency.
    c = cyc; music_tone = 330;
    ex(K_TONE, c + 1, 330);
    step(2); music_tone = 262;
    ex(K_TONE, c + 3, 262);
    step(3);

    // Simultaneous requests: alert first, held click taken in the gap.
    c = cyc; req = 2'b11; req_len0 = 3; req_tone0 = 1000; req_len1 = 2; req_tone1 = 2000;
    ex(K_GNT, c + 1, 2); ex(K_TONE, c + 1, 2000); ex_busy(c + 1, 1'b1);
    ex(K_DONE, c + 9, 1); ex(K_TONE, c + 9, 0);
    ex(K_GNT, c + 10, 1); ex(K_TONE, c + 10, 1000);
    ex(K_DONE, c + 22, 1); ex(K_TONE, c + 22, 0);
    ex(K_TONE, c + 30, 262); ex_busy(c + 30, 1'b0);
    step(1); req = 2'b01;
    step(9); req = 2'b00;
    step(25);

    // Alert preempts a click after 5 cycles; later requests don't disturb the alert.
    c = cyc; req = 2'b01;
    ex(K_GNT, c + 1, 1); ex(K_TONE, c + 1, 1000); ex_busy(c + 1, 1'b1);
    ex(K_GNT, c + 6, 2); ex(K_TONE, c + 6, 2000);
    ex(K_DONE, c + 14, 1); ex(K_TONE, c + 14, 0);
    ex(K_TONE, c + 22, 262); ex_busy(c + 22, 1'b0);
    step(1); req = 2'b00;
    step(4); req = 2'b10;
    step(1); req = 2'b00;
    step(2); req = 2'b11;
    step(1); req = 2'b00;
    step(20);

    // Zero-length click ignored; zero-length alert loses to a valid click.
    c = cyc; req = 2'b01; req_len0 = 0;
    step(1); req = 2'b00;
    step(2); req = 2'b11; req_len1 = 0; req_len0 = 1; req_tone0 = 500;
    ex(K_GNT, c + 4, 1); ex(K_TONE, c + 4, 500); ex_busy(c + 4, 1'b1);
    ex(K_DONE, c + 8, 1); ex(K_TONE, c + 8, 0);
    ex(K_TONE, c + 16, 262); ex_busy(c + 16, 1'b0);
    step(1); req = 2'b00; req_len1 = 2;
    step(16);

    // Reset mid-click, then an alert accepted on the first cycle after reset.
    c = cyc; req = 2'b01; req_len0 = 3; req_tone0 = 1000;
    ex(K_GNT, c + 1, 1); ex(K_TONE, c + 1, 1000); ex_busy(c + 1, 1'b1);
    ex(K_TONE, c + 4, 0); ex_busy(c + 4, 1'b0);
    ex(K_GNT, c + 5, 2); ex(K_TONE, c + 5, 2000); ex_busy(c + 5, 1'b1);
    ex(K_DONE, c + 13, 1); ex(K_TONE, c + 13, 0);
    ex(K_TONE, c + 21, 262); ex_busy(c + 21, 1'b0);
    step(1); req = 2'b00;
    step(2); reset = 1'b1;
    step(1); reset = 1'b0; req = 2'b10;
    step(1); req = 2'b00;
    step(20);

    // Music off: silence, then a click from IDLE returns to IDLE.
    c = cyc; music_en = 1'b0;
    ex(K_TONE, c + 1, 0);
    step(2); req = 2'b01; req_len0 = 1; req_tone0 = 500;
    ex(K_GNT, c + 3, 1); ex(K_TONE, c + 3, 500); ex_busy(c + 3, 1'b1);
    ex(K_DONE, c + 7, 1); ex(K_TONE, c + 7, 0);
    ex_busy(c + 15, 1'b0);
    step(1); req = 2'b00;
    step(16);

    mon_en = 1'b0;
    chk("drain_grant", q_gnt.size(), 32'd0);
    chk("drain_sfx_done", q_done.size(), 32'd0);
    chk("drain_tone", q_tone.size(), 32'd0);
    chk("drain_busy", q_busy.size(), 32'd0);
    chk("drain_music_hold", q_hold.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
